// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder: latches accepted function codes into per-unit selects
// and sequences a fixed-latency MULTU, stalling HI/LO/MULTU until the product is ready.
module alu_ctrl_seq #(
  parameter  int FUNCT_W = 6,
  parameter  int MUL_LAT = 32,
  localparam int CNT_W   = $clog2(MUL_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [FUNCT_W-1:0] funct,
  output logic               in_ready,
  output logic [FUNCT_W-1:0] slt_alu,
  output logic [FUNCT_W-1:0] slt_shift,
  output logic [FUNCT_W-1:0] slt_mul,
  output logic [FUNCT_W-1:0] slt_mux,
  output logic               out_valid,
  output logic               mul_start,
  output logic               mul_busy,
  output logic               illegal
);

  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(36);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(37);
  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(32);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(34);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(42);
  localparam logic [FUNCT_W-1:0] F_SRL   = FUNCT_W'(2);
  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(0);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(25);
  localparam logic [FUNCT_W-1:0] F_HI    = FUNCT_W'(61);
  localparam logic [FUNCT_W-1:0] F_LO    = FUNCT_W'(60);

  localparam logic [FUNCT_W-1:0] MUX_ALU   = FUNCT_W'(63);
  localparam logic [FUNCT_W-1:0] MUX_SHIFT = FUNCT_W'(62);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [FUNCT_W-1:0] alu_n, shift_n, mul_n, mux_n;
  logic               out_valid_n, mul_start_n, illegal_n;
  logic               needs_product, accept;

  assign mul_busy = (state == MUL_BUSY);

  // Anything touching the HI/LO product waits out an in-flight multiply.
  always_comb begin
    needs_product = (funct == F_MULTU) || (funct == F_HI) || (funct == F_LO);
    in_ready      = (state == IDLE) || !needs_product;
    accept        = in_valid && in_ready;

    state_n     = state;
    cnt_n       = cnt;
    alu_n       = slt_alu;
    shift_n     = slt_shift;
    mul_n       = slt_mul;
    mux_n       = slt_mux;
    out_valid_n = 1'b0;
    mul_start_n = 1'b0;
    illegal_n   = 1'b0;

    if (state == MUL_BUSY) begin
      cnt_n = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) state_n = IDLE;
    end

    if (accept) begin
      alu_n       = funct;
      shift_n     = funct;
      mul_n       = funct;
      out_valid_n = 1'b1;
      case (funct)
        F_AND, F_OR, F_ADD, F_SUB, F_SLT: mux_n = MUX_ALU;
        F_SRL, F_SLL:                     mux_n = MUX_SHIFT;
        F_HI:                             mux_n = F_HI;
        F_LO:                             mux_n = F_LO;
        F_MULTU: begin
          mux_n       = F_MULTU;
          mul_start_n = 1'b1;
          cnt_n       = CNT_W'(MUL_LAT);
          state_n     = MUL_BUSY;
        end
        default:                          illegal_n = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      slt_alu   <= '0;
      slt_shift <= '0;
      slt_mul   <= '0;
      slt_mux   <= MUX_ALU;
      out_valid <= 1'b0;
      mul_start <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      slt_alu   <= alu_n;
      slt_shift <= shift_n;
      slt_mul   <= mul_n;
      slt_mux   <= mux_n;
      out_valid <= out_valid_n;
      mul_start <= mul_start_n;
      illegal   <= illegal_n;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with MUL_LAT = 4; expected values are hand-computed
// from the decode table and the 4-cycle multiply window.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] funct;
  logic       in_ready;
  logic [5:0] slt_alu, slt_shift, slt_mul, slt_mux;
  logic       out_valid, mul_start, mul_busy, illegal;

  int n_compared   = 0;
  int n_mismatched = 0;

  alu_ctrl_seq #(.FUNCT_W(6), .MUL_LAT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .funct     (funct),
    .in_ready  (in_ready),
    .slt_alu   (slt_alu),
    .slt_shift (slt_shift),
    .slt_mul   (slt_mul),
    .slt_mux   (slt_mux),
    .out_valid (out_valid),
    .mul_start (mul_start),
    .mul_busy  (mul_busy),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge so they are stable around the rising edge.
  task automatic applyStimulus(input logic v, input logic [5:0] f);
    @(negedge clk);
    in_valid = v;
    funct    = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b1;
    funct    = 6'd32;

    // 1: asynchronous reset mid-cycle
    #13 rst_n = 1'b0;
    #1;
    checkOutput("rst_slt_alu",   slt_alu,   0);
    checkOutput("rst_slt_shift", slt_shift, 0);
    checkOutput("rst_slt_mul",   slt_mul,   0);
    checkOutput("rst_slt_mux",   slt_mux,   63);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_mul_start", mul_start, 0);
    checkOutput("rst_mul_busy",  mul_busy,  0);
    checkOutput("rst_illegal",   illegal,   0);
    checkOutput("rst_in_ready",  in_ready,  1);
    applyStimulus(0, 6'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // 2: ADD then SRL back to back
    applyStimulus(1, 6'd32);
    checkOutput("add_in_ready", in_ready, 1);
    tick();
    checkOutput("add_slt_alu",   slt_alu,   32);
    checkOutput("add_slt_mux",   slt_mux,   63);
    checkOutput("add_out_valid", out_valid, 1);
    applyStimulus(1, 6'd2);
    tick();
    checkOutput("srl_slt_alu",   slt_alu,   2);
    checkOutput("srl_slt_shift", slt_shift, 2);
    checkOutput("srl_slt_mux",   slt_mux,   62);
    checkOutput("srl_out_valid", out_valid, 1);
    applyStimulus(0, 6'd2);
    tick();
    checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("idle_slt_mux",   slt_mux,   62);

    // 3: MULTU, then HI stalled for the full busy window
    applyStimulus(1, 6'd25);
    tick();
    checkOutput("mul_slt_mux", slt_mux, 25);
    checkOutput("mul_slt_mul", slt_mul, 25);
    applyStimulus(1, 6'd61);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("mul_busy_c%0d", k), mul_busy, 1);
      checkOutput($sformatf("mul_start_c%0d", k), mul_start, (k == 0) ? 1 : 0);
      checkOutput($sformatf("hi_stall_c%0d", k), in_ready, 0);
      tick();
    end
    checkOutput("expiry_mul_busy",  mul_busy,  0);
    checkOutput("expiry_in_ready",  in_ready,  1);
    checkOutput("expiry_slt_mux",   slt_mux,   25);
    checkOutput("expiry_out_valid", out_valid, 0);
    tick();
    checkOutput("hi_slt_mux",   slt_mux,   61);
    checkOutput("hi_out_valid", out_valid, 1);

    // 4: SUB slips through a multiply, a second MULTU waits for expiry
    applyStimulus(1, 6'd25);
    tick();
    checkOutput("mul2_start", mul_start, 1);
    applyStimulus(1, 6'd34);
    checkOutput("sub_in_ready", in_ready, 1);
    tick();
    checkOutput("sub_slt_mux",   slt_mux,   63);
    checkOutput("sub_slt_alu",   slt_alu,   34);
    checkOutput("sub_mul_busy",  mul_busy,  1);
    checkOutput("sub_out_valid", out_valid, 1);
    applyStimulus(1, 6'd25);
    checkOutput("multu_stall_a", in_ready, 0);
    tick();
    checkOutput("multu_stall_b", in_ready, 0);
    tick();
    checkOutput("multu_stall_c", in_ready, 0);
    tick();
    checkOutput("mul2_expiry_busy",  mul_busy,  0);
    checkOutput("mul2_expiry_start", mul_start, 0);
    checkOutput("mul2_expiry_ready", in_ready,  1);
    tick();
    checkOutput("mul3_start",   mul_start, 1);
    checkOutput("mul3_busy",    mul_busy,  1);
    checkOutput("mul3_slt_mux", slt_mux,   25);
    applyStimulus(0, 6'd0);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("mul3_done_busy", mul_busy, 0);

    // 5: illegal code after ADD
    applyStimulus(1, 6'd32);
    tick();
    applyStimulus(1, 6'd7);
    tick();
    checkOutput("ill_illegal",   illegal,   1);
    checkOutput("ill_out_valid", out_valid, 1);
    checkOutput("ill_slt_alu",   slt_alu,   7);
    checkOutput("ill_slt_mux",   slt_mux,   63);
    applyStimulus(0, 6'd7);
    tick();
    checkOutput("ill_clear",   illegal,   0);
    checkOutput("ill_ov_clear", out_valid, 0);

    // 6: reset during the second busy cycle aborts the multiply
    applyStimulus(1, 6'd25);
    tick();
    applyStimulus(0, 6'd61);
    checkOutput("ready_no_valid_hi",  in_ready, 0);
    funct = 6'd2;
    #1;
    checkOutput("ready_no_valid_srl", in_ready, 1);
    in_valid = 1'b1;
    funct    = 6'd60;
    tick();
    checkOutput("abort_pre_busy", mul_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_mul_busy",  mul_busy,  0);
    checkOutput("abort_mul_start", mul_start, 0);
    checkOutput("abort_slt_mux",   slt_mux,   63);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("lo_in_ready", in_ready, 1);
    tick();
    checkOutput("lo_slt_mux",   slt_mux,   60);
    checkOutput("lo_out_valid", out_valid, 1);
    checkOutput("lo_mul_start", mul_start, 0);
    checkOutput("lo_mul_busy",  mul_busy,  0);
    applyStimulus(0, 6'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("post_abort_start_%0d", k), mul_start, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
